// File: rtl/map_loader_pkg.sv
// Shared definitions for the maze map loader: FSM state encoding and
// the ones-counter width helper.
package map_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_VERIFY = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Bits needed to count from 0 up to and including `cells`
    function automatic int unsigned cnt_width(input int unsigned cells);
        return $clog2(cells + 1);
    endfunction

endpackage

// File: rtl/map_loader_raster_addr_gen.sv
// Raster-order cell address generator: x runs fastest, wrapping at
// WIDTH-1 into the next row. One instance is shared by load and verify.
module raster_addr_gen
    import map_loader_pkg::*;
#(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned HEIGHT = 16,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned ADDR_H = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_init,
    input  logic              i_step,
    output logic [ADDR_W-1:0] o_x,
    output logic [ADDR_H-1:0] o_y,
    output logic              o_last
);

    localparam logic [ADDR_W-1:0] X_LAST = ADDR_W'(WIDTH - 1);
    localparam logic [ADDR_H-1:0] Y_LAST = ADDR_H'(HEIGHT - 1);

    logic [ADDR_W-1:0] r_x;
    logic [ADDR_H-1:0] r_y;

    // Position register: init returns to (0,0) and wins over step
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_x <= '0;
            r_y <= '0;
        end else if (i_init) begin
            r_x <= '0;
            r_y <= '0;
        end else if (i_step) begin
            if (r_x == X_LAST) begin
                r_x <= '0;
                r_y <= r_y + ADDR_H'(1);
            end else begin
                r_x <= r_x + ADDR_W'(1);
            end
        end
    end

    assign o_x    = r_x;
    assign o_y    = r_y;
    assign o_last = (r_x == X_LAST) && (r_y == Y_LAST);

endmodule

// File: rtl/map_loader.sv
// Maze map loader: streams serial cells into the map memory in raster
// order, then reads the map back and checks the ones-count.
module map_loader
    import map_loader_pkg::*;
#(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned HEIGHT = 16,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned ADDR_H = 4,
    parameter int unsigned CNT_W  = cnt_width(WIDTH * HEIGHT)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_bit_in,
    input  logic              i_bit_valid,
    output logic              o_bit_ready,
    output logic              o_mem_wr,
    output logic              o_mem_rd,
    output logic [ADDR_W-1:0] o_mem_addr_x,
    output logic [ADDR_H-1:0] o_mem_addr_y,
    output logic              o_mem_data_in,
    input  logic              i_mem_data_out,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_error,
    output logic [CNT_W-1:0]  o_ones_count
);

    state_t            r_state;
    logic              r_bit_ready;
    logic              r_mem_rd;
    logic              r_busy;
    logic              r_done;
    logic              r_error;
    logic [CNT_W-1:0]  r_ones_wr;
    logic [CNT_W-1:0]  r_ones_rd;

    logic              w_start_ok;
    logic              w_accept;
    logic              w_step;
    logic              w_init;
    logic              w_last;
    logic [ADDR_W-1:0] w_x;
    logic [ADDR_H-1:0] w_y;

    // Handshake and address-generator control from the registered state
    always_comb begin
        w_start_ok = i_start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
        w_accept   = r_bit_ready && i_bit_valid;
        w_step     = w_accept || r_mem_rd;
        // Rewind on a new load and after the final cell of each pass
        w_init     = w_start_ok || (w_step && w_last);
    end

    raster_addr_gen #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT),
        .ADDR_W (ADDR_W),
        .ADDR_H (ADDR_H)
    ) u_addr (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_init (w_init),
        .i_step (w_step),
        .o_x    (w_x),
        .o_y    (w_y),
        .o_last (w_last)
    );

    // Loader FSM with ones counters and registered status outputs
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state     <= ST_IDLE;
            r_bit_ready <= 1'b0;
            r_mem_rd    <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_ones_wr   <= '0;
            r_ones_rd   <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (i_start) begin
                        r_state     <= ST_LOAD;
                        r_bit_ready <= 1'b1;
                        r_busy      <= 1'b1;
                        r_done      <= 1'b0;
                        r_error     <= 1'b0;
                        r_ones_wr   <= '0;
                        r_ones_rd   <= '0;
                    end
                end
                ST_LOAD: begin
                    if (i_bit_valid) begin
                        r_ones_wr <= r_ones_wr + CNT_W'(i_bit_in);
                        if (w_last) begin
                            r_state     <= ST_VERIFY;
                            r_bit_ready <= 1'b0;
                            r_mem_rd    <= 1'b1;
                        end
                    end
                end
                ST_VERIFY: begin
                    r_ones_rd <= r_ones_rd + CNT_W'(i_mem_data_out);
                    if (w_last) begin
                        r_state  <= ST_DONE;
                        r_mem_rd <= 1'b0;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        // Fold in the final read, which the counter has not yet absorbed
                        r_error  <= (r_ones_rd + CNT_W'(i_mem_data_out)) != r_ones_wr;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_bit_ready   = r_bit_ready;
    assign o_mem_wr      = w_accept;
    assign o_mem_rd      = r_mem_rd;
    assign o_mem_addr_x  = w_x;
    assign o_mem_addr_y  = w_y;
    assign o_mem_data_in = r_bit_ready & i_bit_in;
    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_error       = r_error;
    assign o_ones_count  = r_ones_wr;

endmodule

// File: tb/tb_map_loader.sv
// Bench for map_loader: a 4x4 and a 5x3 instance, each with a bench-side
// memory model and a write/read scoreboard.
module tb_map_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // 4x4 instance
    logic       a_start, a_bit_in, a_valid, a_ready, a_wr, a_rd, a_din, a_dout;
    logic       a_busy, a_done, a_err;
    logic [1:0] a_x, a_y;
    logic [4:0] a_ones;

    // 5x3 instance
    logic       b_start, b_bit_in, b_valid, b_ready, b_wr, b_rd, b_din, b_dout;
    logic       b_busy, b_done, b_err;
    logic [2:0] b_x;
    logic [1:0] b_y;
    logic [3:0] b_ones;

    map_loader #(.WIDTH(4), .HEIGHT(4), .ADDR_W(2), .ADDR_H(2), .CNT_W(5)) u_dut_a (
        .i_clk(clk), .i_rst(rst_n), .i_start(a_start), .i_bit_in(a_bit_in),
        .i_bit_valid(a_valid), .o_bit_ready(a_ready), .o_mem_wr(a_wr), .o_mem_rd(a_rd),
        .o_mem_addr_x(a_x), .o_mem_addr_y(a_y), .o_mem_data_in(a_din),
        .i_mem_data_out(a_dout), .o_busy(a_busy), .o_done(a_done), .o_error(a_err),
        .o_ones_count(a_ones)
    );

    map_loader #(.WIDTH(5), .HEIGHT(3), .ADDR_W(3), .ADDR_H(2), .CNT_W(4)) u_dut_b (
        .i_clk(clk), .i_rst(rst_n), .i_start(b_start), .i_bit_in(b_bit_in),
        .i_bit_valid(b_valid), .o_bit_ready(b_ready), .o_mem_wr(b_wr), .o_mem_rd(b_rd),
        .o_mem_addr_x(b_x), .o_mem_addr_y(b_y), .o_mem_data_in(b_din),
        .i_mem_data_out(b_dout), .o_busy(b_busy), .o_done(b_done), .o_error(b_err),
        .o_ones_count(b_ones)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Memory models with combinational read
    logic mem_a [16];
    logic mem_b [15];
    bit   corrupt_a = 1'b0;
    int   idx_b;

    assign a_dout = mem_a[{a_y, a_x}];
    always_comb begin
        idx_b  = int'(b_y) * 5 + int'(b_x);
        b_dout = (idx_b < 15) ? mem_b[idx_b] : 1'b0;
    end

    // Writes land on the clock edge; optional 0->1 corruption after the last write
    always @(posedge clk) begin
        int k;
        if (a_wr) begin
            mem_a[{a_y, a_x}] <= a_din;
            if (corrupt_a && a_x == 2'd3 && a_y == 2'd3) begin
                k = -1;
                for (int i = 0; i < 15; i++)
                    if (k < 0 && mem_a[i] == 1'b0) k = i;
                if (k >= 0) mem_a[k] <= 1'b1;
            end
        end
        if (b_wr && idx_b < 15) mem_b[idx_b] <= b_din;
    end

    // Scoreboards: expected writes queued by the drivers
    typedef struct packed {
        logic [2:0] x;
        logic [1:0] y;
        logic       d;
    } wr_t;

    wr_t q_a[$];
    wr_t q_b[$];
    wr_t e_a, e_b;
    int  rd_a = 0, rd_b = 0;
    int  unexp_a = 0, unexp_b = 0, excl_a = 0, excl_b = 0;
    logic [2:0] b_last_x;
    logic [1:0] b_last_y;

    always @(negedge clk) begin
        if (a_wr) begin
            if (q_a.size() == 0) unexp_a++;
            else begin
                e_a = q_a.pop_front();
                check("a_wr_addr", {28'd0, a_y, a_x}, {28'd0, e_a.y, e_a.x[1:0]});
                check("a_wr_data", a_din, e_a.d);
            end
        end
        if (a_rd) begin
            check("a_rd_addr", {28'd0, a_y, a_x}, rd_a % 16);
            rd_a++;
        end
        if (a_wr && a_rd) excl_a++;
        if (b_wr) begin
            if (q_b.size() == 0) unexp_b++;
            else begin
                e_b = q_b.pop_front();
                check("b_wr_addr", {27'd0, b_y, b_x}, {27'd0, e_b.y, e_b.x});
                check("b_wr_data", b_din, e_b.d);
                b_last_x = b_x;
                b_last_y = b_y;
            end
        end
        if (b_rd) begin
            check("b_rd_addr", {27'd0, b_y, b_x}, {27'd0, 2'((rd_b % 15) / 5), 3'((rd_b % 15) % 5)});
            rd_b++;
        end
        if (b_wr && b_rd) excl_b++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_start_pulse();
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
    endtask

    task automatic a_beat(input logic b, input int i);
        a_bit_in = b;
        a_valid  = 1'b1;
        q_a.push_back('{x: 3'(i % 4), y: 2'(i / 4), d: b});
        tick();
        a_valid  = 1'b0;
    endtask

    // Streams 16 cells MSB first, optionally pausing after beats 5 and 11
    task automatic a_load(input logic [15:0] bits, input int gap);
        for (int i = 0; i < 16; i++) begin
            a_beat(bits[15-i], i);
            if (gap > 0 && (i == 4 || i == 10))
                repeat (gap) tick();
        end
    endtask

    task automatic a_wait_done();
        for (int c = 0; c < 64 && !a_done; c++) tick();
        check("a_done", a_done, 1);
    endtask

    typedef struct {
        logic [15:0] bits;
        int          gap;
        bit          corrupt;
        logic [4:0]  exp_ones;
        logic        exp_err;
    } vec_t;

    vec_t       vecs[5];
    logic [15:0] img;
    logic [14:0] bbits;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{16'b1010_0110_0000_1111, 0, 1'b0, 5'd8,  1'b0};
        vecs[1] = '{16'b1010_0110_0000_1111, 3, 1'b0, 5'd8,  1'b0};
        vecs[2] = '{16'b1010_0110_0000_1111, 0, 1'b1, 5'd8,  1'b1};
        vecs[3] = '{16'h0000,                0, 1'b0, 5'd0,  1'b0};
        vecs[4] = '{16'hFFFF,                2, 1'b0, 5'd16, 1'b0};

        for (int i = 0; i < 16; i++) mem_a[i] = 1'b0;
        for (int i = 0; i < 15; i++) mem_b[i] = 1'b0;

        rst_n = 1'b0;
        a_start = 0; a_bit_in = 0; a_valid = 0;
        b_start = 0; b_bit_in = 0; b_valid = 0;
        tick();
        tick();
        check("rst_busy",  a_busy, 0);
        check("rst_done",  a_done, 0);
        check("rst_err",   a_err, 0);
        check("rst_ones",  a_ones, 0);
        check("rst_ready", a_ready, 0);
        check("rst_rd",    a_rd, 0);
        rst_n = 1'b1;
        tick();

        // Table-driven full load/verify passes on the 4x4 instance
        for (int k = 0; k < 5; k++) begin
            rd_a = 0;
            unexp_a = 0;
            excl_a = 0;
            corrupt_a = vecs[k].corrupt;
            a_start_pulse();
            check("a_busy_load",  a_busy, 1);
            check("a_ready_load", a_ready, 1);
            check("a_done_clr",   a_done, 0);
            a_load(vecs[k].bits, vecs[k].gap);
            a_wait_done();
            check("a_error",      a_err, vecs[k].exp_err);
            check("a_ones",       a_ones, vecs[k].exp_ones);
            check("a_busy_done",  a_busy, 0);
            check("a_verify_len", rd_a, 16);
            check("a_queue_left", q_a.size(), 0);
            check("a_unexp_wr",   unexp_a, 0);
            check("a_wr_rd_excl", excl_a, 0);
            if (!vecs[k].corrupt) begin
                for (int i = 0; i < 16; i++) img[15-i] = mem_a[i];
                check("a_mem_image", img, vecs[k].bits);
            end
            corrupt_a = 1'b0;
            tick();
        end

        // Asynchronous reset in the middle of a load
        a_start_pulse();
        for (int i = 0; i < 8; i++) a_beat(1'b1, i);
        a_bit_in = 1'b1;
        a_valid  = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_wr",    a_wr, 0);
        check("mid_rst_ready", a_ready, 0);
        check("mid_rst_busy",  a_busy, 0);
        check("mid_rst_ones",  a_ones, 0);
        check("mid_rst_addr",  {a_y, a_x}, 0);
        check("mid_rst_din",   a_din, 0);
        tick();
        rst_n = 1'b1;
        // Valid data while idle must be ignored
        unexp_a = 0;
        tick();
        check("idle_ready", a_ready, 0);
        check("idle_wr",    a_wr, 0);
        tick();
        a_valid = 1'b0;
        check("idle_unexp_wr", unexp_a, 0);

        // Reload from (0,0) with a corrupted cell; start pulsed in VERIFY and DONE
        rd_a = 0;
        corrupt_a = 1'b1;
        a_start_pulse();
        a_load(16'h8001, 0);
        check("verify_entered", a_rd, 1);
        tick();
        tick();
        a_start_pulse();
        check("verify_start_busy",  a_busy, 1);
        check("verify_start_rd",    a_rd, 1);
        check("verify_start_ready", a_ready, 0);
        a_wait_done();
        corrupt_a = 1'b0;
        check("reload_ones",   a_ones, 2);
        check("corrupt_error", a_err, 1);
        check("reload_len",    rd_a, 16);
        check("reload_queue",  q_a.size(), 0);
        tick();
        a_start_pulse();
        check("restart_done",  a_done, 0);
        check("restart_err",   a_err, 0);
        check("restart_busy",  a_busy, 1);
        check("restart_ready", a_ready, 1);
        check("restart_ones",  a_ones, 0);

        // Non-power-of-two geometry on the 5x3 instance
        bbits = 15'b10011_01100_11101;
        rd_b = 0;
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        for (int i = 0; i < 15; i++) begin
            b_bit_in = bbits[14-i];
            b_valid  = 1'b1;
            q_b.push_back('{x: 3'(i % 5), y: 2'(i / 5), d: bbits[14-i]});
            tick();
            b_valid  = 1'b0;
        end
        for (int c = 0; c < 64 && !b_done; c++) tick();
        check("b_done",       b_done, 1);
        check("b_error",      b_err, 0);
        check("b_ones",       b_ones, 9);
        check("b_verify_len", rd_b, 15);
        check("b_queue_left", q_b.size(), 0);
        check("b_unexp_wr",   unexp_b, 0);
        check("b_wr_rd_excl", excl_b, 0);
        check("b_last_x",     b_last_x, 4);
        check("b_last_y",     b_last_y, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
